// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the system-bus arbiter: the FSM state encoding
// (visible to other masters and benches that want to decode arbiter state),
// the width of a master index, and the round-robin index helper.
// No ports; imported with "import bus_arbiter_pkg::*;".
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

  // A master index always fits in 3 bits (up to eight masters).
  localparam int IDX_W       = 3;
  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    TURNAROUND = 2'd2
  } arb_state_e;

  // Index reached by stepping 'offset' places past 'base', wrapping at
  // 'masters'. Used to walk the requesters in round-robin order.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int offset,
                                                input int masters);
    int sum;
    sum = int'(base) + offset;
    return IDX_W'(sum % masters);
  endfunction

endpackage

// File: rtl/bus_arb_rr_picker.sv
// ---------------------------------------------------------------------------
// bus_arb_rr_picker
// Purely combinational round-robin search. Starting just after 'last' and
// wrapping at MASTERS, returns the first requesting master.
// Ports:
//   req    [MASTERS-1:0]  in   request vector
//   last   [2:0]          in   index of the most recent owner
//   winner [2:0]          out  index of the chosen master (0 when none)
//   any                   out  at least one request is present
// ---------------------------------------------------------------------------
module bus_arb_rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int MASTERS = 2
) (
  input  logic [MASTERS-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [IDX_W-1:0]       idx;

  // Zero-pad the request vector so it can be indexed with a full 3-bit
  // index whatever MASTERS is; padded bits never request.
  always_comb begin
    req_ext = '0;
    req_ext[MASTERS-1:0] = req;
  end

  // Walk from the lowest priority (last itself) to the highest (last+1) so
  // the final overwrite is the highest-priority requester.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      idx = rr_index(last, k, MASTERS);
      if (req_ext[idx]) begin
        winner = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin owner selection for the shared system bus. One idle
// (turnaround) cycle separates consecutive owners so no two masters drive
// the data bus together. A watchdog revokes the owner when a rd/wr strobe
// goes unanswered by fc_bus for TIMEOUT_CYCLES cycles (0 disables it).
// Ports:
//   clk                        in   system clock, rising edge
//   rst                        in   asynchronous reset, active low
//   req            [MASTERS-1:0] in   per-master bus request
//   grant          [MASTERS-1:0] out  registered one-hot (or zero) grant
//   rd_bus, wr_bus             in   monitored bus strobes
//   fc_bus                     in   monitored function-complete
//   busy                       out  registered |grant
//   bus_timeout                out  one-cycle pulse when the watchdog fires
//   timeout_master [2:0]       out  master revoked by the last timeout
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MASTERS        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] req,
  output logic [MASTERS-1:0] grant,
  input  logic               rd_bus,
  input  logic               wr_bus,
  input  logic               fc_bus,
  output logic               busy,
  output logic               bus_timeout,
  output logic [IDX_W-1:0]   timeout_master
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit WD_ENABLED = (TIMEOUT_CYCLES > 0);

  arb_state_e             state;
  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       owner;
  logic [CNT_W-1:0]       wd_cnt;
  logic [IDX_W-1:0]       winner;
  logic                   any;
  logic [MAX_MASTERS-1:0] req_ext;
  logic [MASTERS-1:0]     grant_next;
  logic                   owner_req;
  logic                   strobe_pending;
  logic                   wd_fire;

  bus_arb_rr_picker #(
    .MASTERS(MASTERS)
  ) u_picker (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  // Padded copy so the owner's request can be read with a 3-bit index.
  always_comb begin
    req_ext = '0;
    req_ext[MASTERS-1:0] = req;
  end

  // One-hot grant for the current picker winner.
  always_comb begin
    grant_next = '0;
    for (int i = 0; i < MASTERS; i++) begin
      grant_next[i] = (winner == IDX_W'(i));
    end
  end

  assign owner_req      = req_ext[owner];
  assign strobe_pending = (rd_bus | wr_bus) & ~fc_bus;
  // The counter has already seen TIMEOUT_CYCLES unanswered cycles and the
  // strobe is still unanswered on this edge.
  assign wd_fire        = WD_ENABLED && strobe_pending && (wd_cnt == CNT_LIMIT);

  // Arbiter FSM. IDLE and TURNAROUND both grant the picker winner at their
  // end; TURNAROUND exists only to force grant low for one cycle between
  // owners. In GRANTED, an owner release takes priority over a simultaneous
  // timeout so a clean release never raises the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      grant          <= '0;
      busy           <= 1'b0;
      bus_timeout    <= 1'b0;
      timeout_master <= '0;
      last           <= IDX_W'(MASTERS - 1);
      owner          <= '0;
      wd_cnt         <= '0;
    end else begin
      bus_timeout <= 1'b0;
      case (state)
        IDLE, TURNAROUND: begin
          wd_cnt <= '0;
          if (any) begin
            grant <= grant_next;
            busy  <= 1'b1;
            owner <= winner;
            last  <= winner;
            state <= GRANTED;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        GRANTED: begin
          if (!owner_req) begin
            grant  <= '0;
            busy   <= 1'b0;
            wd_cnt <= '0;
            state  <= TURNAROUND;
          end else if (wd_fire) begin
            bus_timeout    <= 1'b1;
            timeout_master <= owner;
            grant          <= '0;
            busy           <= 1'b0;
            wd_cnt         <= '0;
            state          <= TURNAROUND;
          end else if (WD_ENABLED && strobe_pending) begin
            if (wd_cnt != CNT_LIMIT) begin
              wd_cnt <= wd_cnt + CNT_W'(1);
            end
          end else begin
            wd_cnt <= '0;
          end
        end
        default: begin
          grant  <= '0;
          busy   <= 1'b0;
          wd_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter with four masters and an 8-cycle watchdog.
// Every expected value below is worked out by hand from the arbitration
// rules: round-robin from last+1, one zero-grant cycle between owners,
// timeout after eight unanswered strobe cycles.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int MASTERS = 4;
  localparam int TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [MASTERS-1:0] req;
  logic [MASTERS-1:0] grant;
  logic               rd_bus;
  logic               wr_bus;
  logic               fc_bus;
  logic               busy;
  logic               bus_timeout;
  logic [2:0]         timeout_master;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .MASTERS        (MASTERS),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .grant          (grant),
    .rd_bus         (rd_bus),
    .wr_bus         (wr_bus),
    .fc_bus         (fc_bus),
    .busy           (busy),
    .bus_timeout    (bus_timeout),
    .timeout_master (timeout_master)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then let one rising edge sample them.
  task automatic applyStimulus(input logic [MASTERS-1:0] r, input logic rd,
                               input logic wr, input logic fc);
    req    = r;
    rd_bus = rd;
    wr_bus = wr;
    fc_bus = fc;
    tick();
  endtask

  task automatic checkGrant(input string tag, input logic [MASTERS-1:0] exp_grant);
    checkOutput({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(|exp_grant));
  endtask

  initial begin
    int own;
    rst    = 1'b0;
    req    = '0;
    rd_bus = 1'b0;
    wr_bus = 1'b0;
    fc_bus = 1'b0;
    tick();
    tick();
    checkGrant("reset", 4'b0000);
    checkOutput("reset_timeout", 32'(bus_timeout), 32'd0);
    checkOutput("reset_tmaster", 32'(timeout_master), 32'd0);
    rst = 1'b1;

    // Single request and release
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkGrant("idle", 4'b0000);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkGrant("single", 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkGrant("single_release", 4'b0000);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkGrant("single_idle", 4'b0000);

    // Fairness: masters 0 and 1 always request, owner releases after 3 cycles.
    // last=0 here, so master 1 goes first.
    own = 1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
        checkGrant($sformatf("fair_r%0d_c%0d", r, c), 4'(1 << own));
      end
      applyStimulus(4'b0011 & ~4'(1 << own), 1'b0, 1'b0, 1'b0);
      checkGrant($sformatf("fair_gap_r%0d", r), 4'b0000);
      own = 1 - own;
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Wrap-around: make master 3 the last owner, then 1001 picks master 0
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkGrant("m3_grant", 4'b1000);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    checkGrant("wrap_to_m0", 4'b0001);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkGrant("wrap_release", 4'b0000);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    checkGrant("wrap_to_m3", 4'b1000);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    checkGrant("owner_holds", 4'b1000);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkGrant("handover_gap", 4'b0000);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkGrant("handover_direct", 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Timeout on owner 1 with master 0 also waiting
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    checkGrant("to_owner1", 4'b0010);
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("to_wait%0d_pulse", i), 32'(bus_timeout), 32'd0);
      checkOutput($sformatf("to_wait%0d_grant", i), 32'(grant), 32'b0010);
    end
    applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0);
    checkOutput("to_fire_pulse", 32'(bus_timeout), 32'd1);
    checkOutput("to_fire_grant", 32'(grant), 32'd0);
    checkOutput("to_fire_tmaster", 32'(timeout_master), 32'd1);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    checkOutput("to_pulse_once", 32'(bus_timeout), 32'd0);
    checkGrant("to_next_m0", 4'b0001);
    checkOutput("to_tmaster_sticky", 32'(timeout_master), 32'd1);

    // fc_bus on the 8th strobe cycle restarts the count: no pulse
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
    checkOutput("fc_clear_pulse", 32'(bus_timeout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("fc_after%0d_pulse", i), 32'(bus_timeout), 32'd0);
    end
    checkGrant("fc_still_owner", 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Release on the same edge the timeout would fire: plain release
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkGrant("simul_owner", 4'b0001);
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("simul_no_pulse", 32'(bus_timeout), 32'd0);
    checkGrant("simul_release", 4'b0000);
    checkOutput("simul_tmaster", 32'(timeout_master), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-ownership, then master 0 first again
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkGrant("pre_reset_owner", 4'b0001);
    req = 4'b0011;
    #2;
    rst = 1'b0;
    #1;
    checkGrant("async_reset", 4'b0000);
    checkOutput("async_reset_tmaster", 32'(timeout_master), 32'd0);
    #2;
    rst = 1'b1;
    tick();
    checkGrant("post_reset_m0", 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkGrant("final_release", 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single system bus (addr/data/rd/wr/mask/fc) between up to eight bus masters, e.g. the CPU core and a DMA engine. Each master drives `bus_req` and waits for its `bus_grant` bit. The arbiter inserts one turnaround cycle between owners so that no two masters ever drive `data_bus` in the same cycle. It also watches the active transaction and revokes ownership when a slave fails to answer with `fc_bus` within a bounded time.

## Interface
- `MASTERS`, default 2: number of requesters, legal range 1..8.
- `TIMEOUT_CYCLES`, default 256: number of unanswered rd/wr cycles before revocation; 0 disables the watchdog.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `req`  input  MASTERS  per-master request; bit i is master i's `bus_req`.
- `grant`  output  MASTERS  per-master grant; one-hot or zero, registered.
- `rd_bus`  input  1  monitored bus read strobe.
- `wr_bus`  input  1  monitored bus write strobe.
- `fc_bus`  input  1  monitored bus function-complete.
- `busy`  output  1  high while any grant bit is high.
- `bus_timeout`  output  1  one-cycle pulse when the watchdog fires.
- `timeout_master`  output  3  index of the master revoked by the last timeout; sticky.

## Operation
- States: IDLE, GRANTED, TURNAROUND. Encoded in 2 bits.
- Round-robin pointer `last` (3 bits):
  - Winner = first i with `req[i]`=1, searching `last+1`, `last+2`, … with wrap at MASTERS.
  - `last` is set to the winner when a grant is issued.
- IDLE: if any `req` is high, grant the winner and go to GRANTED. Otherwise stay in IDLE with `grant`=0.
- GRANTED: hold `grant` constant while `req[owner]`=1. Requests from other masters are ignored while the owner holds.
- Release: when `req[owner]`=0, clear `grant` and go to TURNAROUND.
- TURNAROUND: `grant`=0 for exactly one cycle, then go to IDLE.
  - The winner is evaluated in TURNAROUND and granted directly at the end of it, so no extra IDLE cycle is spent when a request is pending.
- Watchdog counter:
  - Counts cycles in GRANTED with (`rd_bus`|`wr_bus`) & !`fc_bus`.
  - Clears on `fc_bus`=1, on no strobe, or on leaving GRANTED.
  - Saturates; it never wraps.
- Timeout fires when the counter reaches TIMEOUT_CYCLES. On firing:
  - `bus_timeout`=1 for one cycle.
  - `timeout_master` is set to the owner index.
  - `grant` is cleared and the arbiter goes to TURNAROUND.
  - `last` keeps the revoked owner, so that master is searched last next time.
- A revoked master that still asserts `req` competes normally after TURNAROUND.
- Simultaneous events: if the owner drops `req` on the same cycle the timeout would fire, it is a normal release and no pulse is raised.
- Unimplemented bits: `req` bits at index ≥ MASTERS do not exist. When MASTERS=1, the turnaround still applies.

## Timing
- Reset values: state IDLE, `grant`=0, `busy`=0, `bus_timeout`=0, `timeout_master`=0, `last`=MASTERS-1 (master 0 wins first), counter 0.
- Reset asserted mid-ownership drops `grant` immediately, asynchronously.
- Grant latency:
  - A `req` sampled high in IDLE at edge N gives `grant` high after edge N (1 cycle).
  - No combinational path from `req` to `grant`.
- Handover:
  - Owner `req` sampled low at edge k: `grant` goes low after edge k.
  - The next winner's `grant` goes high after edge k+1.
  - The minimum gap between owners is one full cycle.
- Timeout timing: with TIMEOUT_CYCLES=T and a strobe held without `fc_bus` from edge m, `bus_timeout` pulses after edge m+T and `grant` is 0 in the same cycle.
- `busy` is registered, equal to |`grant`.

## Structure
- State encodings go in a shared include `BusArbStates.vh`, alongside the CPU state include. This lets other masters and benches decode arbiter state.
- One combinational sub-module, `bus_arb_rr_picker`:
  - Inputs: `req`, `last`.
  - Outputs: `winner` index and `any`.
  - This isolates the wrap-around search.
- Top level holds the FSM, grant register, pointer and watchdog. Expected size is about 150–250 lines total.

## Test plan
- Single request: MASTERS=2, reset released, `req`=01 → `grant`=01 one cycle later. Drop `req` → `grant`=00, one turnaround cycle, then IDLE.
- Fairness: `req`=11 held continuously with each owner releasing after 3 cycles → grants alternate 01, 10, 01, … with exactly one zero-grant cycle between them.
- Wrap: MASTERS=4, `last`=3, `req`=1001 → master 0 wins. Then with `req`=1001 again → master 3 wins.
- Timeout: TIMEOUT_CYCLES=8, owner 1 asserts `rd_bus` with `fc_bus`=0 → after 8 cycles `bus_timeout` pulses once, `timeout_master`=1, `grant`=00, and master 0 is granted next if it is requesting. With `fc_bus` at cycle 7 → no pulse.
- Async reset: assert `rst`=0 mid-grant between clock edges → `grant`=00 immediately. After release, master 0 has first priority.
